// File: rtl/operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : operand_loader
// Description : Double-banked operand staging for an N_OPND-input controller.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_loader #(
  parameter int WIDTH  = 16,
  parameter int N_OPND = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    in_ready,
  input  logic                    op_ready,
  output logic                    start,
  input  logic                    done_next,
  output logic [N_OPND*WIDTH-1:0] opnd_bus,
  output logic [1:0]              bank_full,
  output logic                    busy
);

  localparam int c_CNT_W = (N_OPND > 1) ? $clog2(N_OPND) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(N_OPND - 1);

  logic [N_OPND-1:0][WIDTH-1:0] r_bank [2];
  logic                         r_wr_bank;
  logic                         r_rd_bank;
  logic [c_CNT_W-1:0]           r_wr_cnt;
  logic [1:0]                   r_bank_full;
  logic                         r_inflight;

  logic       w_in_ready;
  logic       w_accept;
  logic       w_last;
  logic       w_start;
  logic       w_release;
  logic [1:0] w_full_nxt;

  assign w_in_ready = ~r_bank_full[r_wr_bank];
  assign w_accept   = in_valid & w_in_ready;
  assign w_last     = (r_wr_cnt == c_LAST);
  assign w_start    = r_bank_full[r_rd_bank] & ~r_inflight & op_ready;
  assign w_release  = done_next & r_inflight;

  // Fill and release always touch different banks: the read bank is full
  // whenever a computation is in flight, so it can never be the write target.
  always_comb begin
    w_full_nxt = r_bank_full;
    if (w_accept && w_last) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_release)          w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) r_bank[b] <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_bank_full <= 2'b00;
      r_inflight  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_bank[r_wr_bank][r_wr_cnt] <= in_data;
        if (w_last) begin
          r_wr_cnt  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
        end
      end
      r_bank_full <= w_full_nxt;
      if (w_release) begin
        r_rd_bank  <= ~r_rd_bank;
        r_inflight <= 1'b0;
      end else if (w_start) begin
        r_inflight <= 1'b1;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign start     = w_start;
  assign busy      = r_inflight;
  assign bank_full = r_bank_full;
  assign opnd_bus  = r_bank[r_rd_bank];

endmodule
`default_nettype wire

// File: tb/tb_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_loader
// Description : Directed bench for operand_loader with a batch-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_loader;

  localparam int WIDTH  = 16;
  localparam int N_OPND = 8;
  localparam int BUS_W  = WIDTH * N_OPND;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             op_ready = 1'b0;
  logic             start;
  logic             done_next = 1'b0;
  logic [BUS_W-1:0] opnd_bus;
  logic [1:0]       bank_full;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  operand_loader #(.WIDTH(WIDTH), .N_OPND(N_OPND)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .op_ready(op_ready), .start(start),
    .done_next(done_next), .opnd_bus(opnd_bus), .bank_full(bank_full),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: completed batches wait in arrival order; the oldest is the one issued.
  logic [BUS_W-1:0] m_batches[$];
  logic [BUS_W-1:0] m_partial;
  int               m_cnt;
  bit               m_inflight;
  bit               m_rd;

  initial begin
    m_partial = '0; m_cnt = 0; m_inflight = 0; m_rd = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_batches.delete(); m_partial = '0; m_cnt = 0; m_inflight = 0; m_rd = 0;
      end
      begin
        bit         e_rdy, e_start, acc, rel;
        logic [1:0] e_full;
        int         nf;
        nf      = m_batches.size();
        e_rdy   = (nf < 2);
        e_start = (nf > 0) && !m_inflight && op_ready;
        e_full  = (nf == 0) ? 2'b00 : (nf == 1) ? (m_rd ? 2'b10 : 2'b01) : 2'b11;
        check("in_ready", BUS_W'(in_ready), BUS_W'(e_rdy));
        check("start", BUS_W'(start), BUS_W'(e_start));
        check("busy", BUS_W'(busy), BUS_W'(m_inflight));
        check("bank_full", BUS_W'(bank_full), BUS_W'(e_full));
        if (rst) check("opnd_bus_rst", opnd_bus, '0);
        else if (nf > 0) check("opnd_bus", opnd_bus, m_batches[0]);
        if (!rst) begin
          acc = in_valid && e_rdy;
          rel = done_next && m_inflight;
          if (rel) begin
            void'(m_batches.pop_front());
            m_rd = !m_rd;
            m_inflight = 0;
          end
          if (e_start) m_inflight = 1;
          if (acc) begin
            m_partial[m_cnt*WIDTH +: WIDTH] = in_data;
            m_cnt++;
            if (m_cnt == N_OPND) begin
              m_batches.push_back(m_partial);
              m_cnt = 0;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; done_next = 1'b0; op_ready = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic fill(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(base + i);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic check_words(input string nm, input int base);
    for (int k = 0; k < N_OPND; k++)
      check(nm, BUS_W'(opnd_bus[k*WIDTH +: WIDTH]), BUS_W'(base + k));
  endtask

  task automatic pulse_done();
    done_next = 1'b1;
    step();
    done_next = 1'b0;
  endtask

  initial begin
    // Reset state
    step(); step();
    check("rst_in_ready", BUS_W'(in_ready), BUS_W'(1));
    check("rst_start", BUS_W'(start), '0);
    check("rst_busy", BUS_W'(busy), '0);
    check("rst_opnd_bus", opnd_bus, '0);
    rst = 1'b0;

    // Single fill
    op_ready = 1'b1;
    fill(1, 8);
    check("single_start", BUS_W'(start), BUS_W'(1));
    check_words("single_word", 1);
    step();
    check("single_start_once", BUS_W'(start), '0);
    step(); step();
    check("single_busy", BUS_W'(busy), BUS_W'(1));
    pulse_done();
    check("single_idle", BUS_W'(busy), '0);

    // Ping-pong
    do_reset();
    op_ready = 1'b1;
    fill(1, 16);
    check("pp_in_ready_low", BUS_W'(in_ready), '0);
    check("pp_bank_full", BUS_W'(bank_full), BUS_W'(2'b11));
    pulse_done();
    check("pp_in_ready_back", BUS_W'(in_ready), BUS_W'(1));
    check("pp_restart", BUS_W'(start), BUS_W'(1));
    check_words("pp_word", 9);
    step();
    pulse_done();

    // op_ready gating
    do_reset();
    fill(1, 8);
    step();
    check("opr_start_low", BUS_W'(start), '0);
    check("opr_full0", BUS_W'(bank_full[0]), BUS_W'(1));
    op_ready = 1'b1;
    #1;
    check("opr_start_same_cycle", BUS_W'(start), BUS_W'(1));
    step();
    pulse_done();

    // Spurious done_next while idle
    do_reset();
    done_next = 1'b1;
    step(); step(); step();
    done_next = 1'b0;
    check("spur_full", BUS_W'(bank_full), '0);
    fill(32, 8);
    check("spur_rd_bank0", BUS_W'(bank_full), BUS_W'(2'b01));

    // Reset mid-operation
    do_reset();
    op_ready = 1'b1;
    fill(1, 8);
    step();
    fill(50, 5);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", BUS_W'(busy), '0);
    check("mid_rst_full", BUS_W'(bank_full), '0);
    check("mid_rst_bus", opnd_bus, '0);
    step();
    rst = 1'b0; op_ready = 1'b0;
    fill(70, 8);
    check("mid_rst_refill_bank0", BUS_W'(bank_full), BUS_W'(2'b01));
    check_words("mid_rst_word", 70);

    // Final accept into bank 1 coincides with release of bank 0
    do_reset();
    op_ready = 1'b1;
    fill(256, 8);
    step();
    fill(512, 7);
    in_valid = 1'b1; in_data = WIDTH'(519); done_next = 1'b1;
    step();
    in_valid = 1'b0; done_next = 1'b0;
    check("sim_bank_full", BUS_W'(bank_full), BUS_W'(2'b10));
    check("sim_start", BUS_W'(start), BUS_W'(1));
    check_words("sim_word", 512);
    step();
    pulse_done();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
